seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised Mealy serial-pattern detector: the next generation of the fixed 1111001 overlapping detector. The pattern value and length are parameters, overlapping versus non-overlapping matching is selectable at run time, input bits can be qualified with an enable, and an optional saturating match counter is available. It sits on a 1-bit serial stream next to the other detector blocks and drives a single-cycle match flag to downstream control.

## Interface
- PAT_W, 7, pattern length in bits, legal range 2..32
- PATTERN, 7'b1111001, PAT_W-bit pattern; bit PAT_W-1 is the first bit received
- COUNT_W, 8, width of match_cnt
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- x  input  1  serial data bit
- en  input  1  x qualifier; when low, x is ignored for that cycle
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- cnt_clr  input  1  synchronous clear of match_cnt
- z  output  1  Mealy match flag; combinational from current x, en and state
- match_cnt  output  COUNT_W  number of matches since reset or last clear

## Operation
- State:
  - hist: PAT_W-1 bits holding the most recent accepted bits, newest in bit 0.
  - fill: saturating count of valid history bits, 0..PAT_W-1.
- Match: z = en & (fill == PAT_W-1) & ({hist, x} == PATTERN).
- Accepted bit (en=1):
  - If z=1 and overlap=0: hist cleared, fill set to 0. The next match needs PAT_W fresh bits.
  - Otherwise: hist shifts left with x entering bit 0, and fill increments, saturating at PAT_W-1.
- en=0: hist and fill hold, z=0, counter holds.
- overlap is evaluated only in the cycle where z=1, so a mode change takes effect at the next match.
- Counter:
  - match_cnt increments by 1 at the edge where z=1 and saturates at all-ones.
  - cnt_clr=1 clears it. If cnt_clr and z are both 1 in the same cycle, match_cnt becomes 1 (clear, then count).
- Reset, at any time including mid-match: hist=0, fill=0, match_cnt=0. z=0 while rst is low.

## Timing
- z is valid in the same cycle as the final pattern bit (Mealy, zero latency). Downstream samples it at the next rising edge.
- z is high for exactly one cycle per match.
- match_cnt reflects a match one cycle after z.
- Reset deassertion is synchronised externally. The first accepted bit is the first en=1 edge after rst goes high.
- Back-to-back matches in overlap mode are as close as the pattern's self-overlap allows. For 1111001 that is every 6 bits, because the trailing 1 is reused.

## Configuration
- SEQ_DET_COUNT_EN defined: the match_cnt register and the cnt_clr logic are built as described above.
- SEQ_DET_COUNT_EN undefined: match_cnt is tied to 0, cnt_clr is ignored, and no counter flops are generated. z behaviour is identical in both builds.

## Structure
- Package seq_det_pkg holds:
  - default constants DEF_PAT_W=7, DEF_PATTERN=7'b1111001, DEF_COUNT_W=8;
  - a function that checks PAT_W against PATTERN width, used in an elaboration-time assertion.
- One sub-module, seq_det_hist, holds the history shift register and fill counter. Its inputs are shift, flush and x; its outputs are hist and full.
- The top level holds the compare, the z generation and the optional counter.

## Test plan
1. Defaults, overlap=1, en=1, stream 1111001111001 -> z=1 at bit 7 and bit 13; match_cnt=2.
2. Defaults, overlap=0, same stream -> z=1 at bit 7 only; match_cnt=1.
3. Defaults, stream 11111001, en=0 for one cycle inserted between bit 3 and bit 4 -> z=1 on the final 1 only; no match is lost or created by the stall.
4. Assert rst low after bits 111100 of a matching stream, release, then send 1 -> z stays 0. A full 1111001 afterwards -> z=1 and match_cnt=1.
5. PAT_W=4, PATTERN=4'b1010, overlap=1, stream 1010101 -> z at bits 4 and 6. With overlap=0 -> z at bit 4 only.
6. COUNT_W=2 with SEQ_DET_COUNT_EN defined: 5 matches -> match_cnt saturates at 3. Then cnt_clr in the same cycle as z -> match_cnt=1. In a build without the macro, match_cnt stays 0 throughout.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared defaults and configuration checks for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int unsigned DEF_PAT_W   = 7;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 7'b1111001;
    localparam int unsigned DEF_COUNT_W = 8;

    localparam int unsigned MIN_PAT_W = 2;
    localparam int unsigned MAX_PAT_W = 32;

    // True when the pattern length is legal and the pattern value is exactly that wide.
    function automatic bit pat_cfg_ok(input int unsigned pat_w, input int unsigned pattern_bits);
        return (pat_w >= MIN_PAT_W) && (pat_w <= MAX_PAT_W) && (pattern_bits == pat_w);
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register and saturating fill counter for the serial pattern detector.
// hist holds the last PAT_W-1 accepted bits, newest in bit 0; full is high once
// PAT_W-1 bits have been accepted since reset or the last flush.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             flush,
    input  logic             x,
    output logic [PAT_W-2:0] hist,
    output logic             full
);

    localparam int unsigned HIST_W = PAT_W - 1;
    localparam int unsigned FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [HIST_W-1:0] hist_q;
    logic [HIST_W-1:0] hist_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;

    // State register: history bits and fill level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    // Next state: flush wins over shift; shifting drops the oldest bit off the top.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (flush) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift) begin
            hist_d = HIST_W'({hist_q, x});
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    assign hist = hist_q;
    assign full = (fill_q == FILL_MAX);

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with selectable overlapping matching,
// an input qualifier and an optional saturating match counter.
// Build option: define SEQ_DET_COUNT_EN to build the match_cnt register and cnt_clr
// logic; without it match_cnt is tied to zero and cnt_clr is ignored.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W   = DEF_PAT_W,
    parameter              PATTERN = DEF_PATTERN,
    parameter int unsigned COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               en,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic [COUNT_W-1:0] match_cnt
);

    localparam logic [PAT_W-1:0] PAT = PAT_W'(PATTERN);

    // Reject a pattern whose width disagrees with PAT_W or an out-of-range length.
    if (!pat_cfg_ok(PAT_W, $bits(PATTERN))) begin : g_cfg_err
        $error("seq_detector_param: PAT_W=%0d illegal or PATTERN width %0d mismatched",
               PAT_W, $bits(PATTERN));
    end

    logic [PAT_W-2:0] hist;
    logic             full;
    logic [PAT_W-1:0] cand;
    logic             flush;

    seq_det_hist #(
        .PAT_W (PAT_W)
    ) u_hist (
        .clk   (clk),
        .rst   (rst),
        .shift (en),
        .flush (flush),
        .x     (x),
        .hist  (hist),
        .full  (full)
    );

    // Mealy match: the history plus the bit arriving now must equal the pattern.
    assign cand  = {hist, x};
    assign z     = en & full & (cand == PAT);
    // Non-overlapping mode restarts collection from scratch after a match.
    assign flush = z & ~overlap;

`ifdef SEQ_DET_COUNT_EN
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_d;

    // Match counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Clear first, then count, so a clear coinciding with a match leaves one.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end
        if (z && (cnt_d != CNT_MAX)) begin
            cnt_d = cnt_d + COUNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a default 1111001 instance and a 4-bit
// 1010 instance with a 2-bit counter share the same stimulus.
module tb_seq_detector_param;

`ifdef SEQ_DET_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       x;
    logic       en;
    logic       overlap;
    logic       cnt_clr;
    logic       z7;
    logic       z4;
    logic [7:0] cnt7;
    logic [1:0] cnt4;

    always #5 clk = ~clk;

    seq_detector_param dut7 (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .en        (en),
        .overlap   (overlap),
        .cnt_clr   (cnt_clr),
        .z         (z7),
        .match_cnt (cnt7)
    );

    seq_detector_param #(
        .PAT_W   (4),
        .PATTERN (4'b1010),
        .COUNT_W (2)
    ) dut4 (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .en        (en),
        .overlap   (overlap),
        .cnt_clr   (cnt_clr),
        .z         (z4),
        .match_cnt (cnt4)
    );

    typedef struct {
        bit z7;
        int cnt7;
        bit z4;
        int cnt4;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   z7_hits = 0;
    int   z4_hits = 0;

    // Reference model state: accepted bits since reset/flush, and match counts.
    bit acc7[$];
    bit acc4[$];
    int mcnt7 = 0;
    int mcnt4 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    // Last w-1 accepted bits followed by xb spell the pattern, oldest bit first.
    function automatic bit pat_hit(input bit q[$], input int w, input logic [31:0] pat, input bit xb);
        if (q.size() < w - 1) return 1'b0;
        for (int i = 0; i < w - 1; i++) begin
            if (q[q.size() - (w - 1) + i] != pat[w - 1 - i]) return 1'b0;
        end
        return xb == pat[0];
    endfunction

    task automatic model_step(inout bit q[$], inout int cnt, input int w, input logic [31:0] pat,
                              input int cmax, input bit xb, input bit e, input bit ov,
                              input bit clr, output bit zo);
        zo = e && pat_hit(q, w, pat, xb);
        if (clr) cnt = 0;
        if (zo && cnt < cmax) cnt++;
        if (e) begin
            if (zo && !ov) begin
                q.delete();
            end else begin
                q.push_back(xb);
                if (q.size() > 40) void'(q.pop_front());
            end
        end
    endtask

    // One clock of normal operation: drive inputs, predict outputs, queue the prediction.
    task automatic step(input bit xb, input bit e, input bit ov, input bit clr);
        exp_t ex;
        bit   zz;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        x       = xb;
        en      = e;
        overlap = ov;
        cnt_clr = clr;
        ex.cnt7 = CNT_ON ? mcnt7 : 0;
        ex.cnt4 = CNT_ON ? mcnt4 : 0;
        model_step(acc7, mcnt7, 7, 32'b1111001, 255, xb, e, ov, clr, zz);
        ex.z7 = zz;
        model_step(acc4, mcnt4, 4, 32'b1010, 3, xb, e, ov, clr, zz);
        ex.z4 = zz;
        sb.push_back(ex);
    endtask

    // Hold reset low for n cycles with live-looking inputs; outputs must stay quiet.
    task automatic reset_cycles(input int n);
        exp_t ex;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst     = 1'b0;
            x       = 1'($urandom);
            en      = 1'b1;
            cnt_clr = 1'b0;
            acc7.delete();
            acc4.delete();
            mcnt7   = 0;
            mcnt4   = 0;
            ex.z7   = 1'b0;
            ex.cnt7 = 0;
            ex.z4   = 1'b0;
            ex.cnt4 = 0;
            sb.push_back(ex);
        end
    endtask

    task automatic send_bits(input string s, input bit ov);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i] == "1", 1'b1, ov, 1'b0);
        end
    endtask

    // Monitor: compare DUT outputs against the queued prediction mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("z7", 32'(z7), 32'(e.z7));
                chk("cnt7", 32'(cnt7), e.cnt7);
                chk("z4", 32'(z4), 32'(e.z4));
                chk("cnt4", 32'(cnt4), e.cnt4);
                if (z7 === 1'b1) z7_hits++;
                if (z4 === 1'b1) z4_hits++;
            end
        end
    end

    initial begin
        int h;
        rst     = 1'b0;
        x       = 1'b0;
        en      = 1'b0;
        overlap = 1'b1;
        cnt_clr = 1'b0;
        reset_cycles(2);

        // Overlapping defaults: two matches sharing the trailing 1.
        h = z7_hits;
        send_bits("1111001111001", 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_hits", 32'(z7_hits - h), 2);
        chk("t1_cnt", 32'(cnt7), CNT_ON ? 2 : 0);

        // Non-overlapping: second pattern lacks fresh bits.
        reset_cycles(1);
        h = z7_hits;
        send_bits("1111001111001", 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_hits", 32'(z7_hits - h), 1);
        chk("t2_cnt", 32'(cnt7), CNT_ON ? 1 : 0);

        // Stall inside the stream neither loses nor creates a match.
        reset_cycles(1);
        h = z7_hits;
        send_bits("111", 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits("11001", 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_hits", 32'(z7_hits - h), 1);

        // Reset mid-match discards history.
        reset_cycles(1);
        send_bits("111100", 1'b1);
        reset_cycles(2);
        h = z7_hits;
        send_bits("1", 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_no_hit", 32'(z7_hits - h), 0);
        send_bits("1111001", 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_hits", 32'(z7_hits - h), 1);
        chk("t4_cnt", 32'(cnt7), CNT_ON ? 1 : 0);

        // Short pattern with self-overlap, both modes.
        reset_cycles(1);
        h = z4_hits;
        send_bits("1010101", 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_ov_hits", 32'(z4_hits - h), 2);
        reset_cycles(1);
        h = z4_hits;
        send_bits("1010101", 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_nov_hits", 32'(z4_hits - h), 1);

        // Counter saturation, then clear coinciding with a match.
        reset_cycles(1);
        send_bits("1010101010101", 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_sat", 32'(cnt4), CNT_ON ? 3 : 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_clr_hit", 32'(cnt4), CNT_ON ? 1 : 0);

        // Randomised traffic with injected patterns, stalls, mode flips, clears and resets.
        begin
            bit ov = 1'b1;
            for (int n = 0; n < 3000; n++) begin
                int r = $urandom_range(0, 999);
                if (r < 3) begin
                    reset_cycles($urandom_range(1, 2));
                end else if (r < 40) begin
                    send_bits("1111001", ov);
                end else begin
                    if ($urandom_range(0, 99) < 2) ov = ~ov;
                    step(1'($urandom), $urandom_range(0, 99) < 85, ov,
                         $urandom_range(0, 99) < 3);
                end
            end
        end

        step(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
